// File: rtl/vector_division_dispatch_pkg.sv
// Shared vector-unit types used by the division dispatch sequencer.
package vector_division_dispatch_pkg;

  localparam int VLEN           = 128;
  localparam int VRF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {DIV_DIVU, DIV_DIV, DIV_REMU, DIV_REM} div_op_t;
  typedef enum logic [1:0] {SEW_8, SEW_16, SEW_32, SEW_64}        sew_t;

  // Operation, element width and sign control carried with each command.
  typedef struct packed {
    div_op_t op;
    sew_t    sew;
  } execution_vector_t;

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WRITE} vdd_state_t;

endpackage

// File: rtl/vector_division_dispatch.sv
// Sequencer: accept a divide command, read both VRF sources, present them
// to the division unit for one cycle, wait out its latency, write back.
module vector_division_dispatch
  import vector_division_dispatch_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  execution_vector_t         cmd_execution_vector,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_vs2_addr,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_vs1_addr,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_vd_addr,
  output logic                      vrf_rd_en,
  output logic [VRF_ADDR_WIDTH-1:0] vrf_rd_addr_a,
  output logic [VRF_ADDR_WIDTH-1:0] vrf_rd_addr_b,
  input  logic [VLEN-1:0]           vrf_rd_data_a,
  input  logic [VLEN-1:0]           vrf_rd_data_b,
  output execution_vector_t         div_execution_vector,
  output logic [VLEN-1:0]           div_vs2,
  output logic [VLEN-1:0]           div_vs1,
  input  logic [VLEN-1:0]           div_vd,
  output logic                      vrf_wr_en,
  output logic [VRF_ADDR_WIDTH-1:0] vrf_wr_addr,
  output logic [VLEN-1:0]           vrf_wr_data,
  output logic                      busy,
  output logic                      done
);

  // WAIT exits when the counter hits LAT-2; unused when LAT == 1.
  localparam logic [3:0] WAIT_LAST = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

  vdd_state_t                state_q, state_nxt;
  execution_vector_t         ev_q;
  logic [VRF_ADDR_WIDTH-1:0] vs2_q, vs1_q, vd_q;
  logic [3:0]                cnt_q;

  // State register, command latches and wait counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ev_q    <= '0;
      vs2_q   <= '0;
      vs1_q   <= '0;
      vd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE && cmd_valid && !flush) begin
        ev_q  <= cmd_execution_vector;
        vs2_q <= cmd_vs2_addr;
        vs1_q <= cmd_vs1_addr;
        vd_q  <= cmd_vd_addr;
      end
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 4'd1;
    end
  end

  // Next-state and per-state outputs; everything idles at zero by default.
  always_comb begin
    state_nxt            = state_q;
    cmd_ready            = 1'b0;
    vrf_rd_en            = 1'b0;
    vrf_rd_addr_a        = '0;
    vrf_rd_addr_b        = '0;
    div_execution_vector = '0;
    div_vs2              = '0;
    div_vs1              = '0;
    vrf_wr_en            = 1'b0;
    vrf_wr_addr          = '0;
    vrf_wr_data          = '0;
    done                 = 1'b0;
    busy                 = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = !flush;
        if (cmd_valid) state_nxt = READ;
      end
      READ: begin
        vrf_rd_en     = 1'b1;
        vrf_rd_addr_a = vs2_q;
        vrf_rd_addr_b = vs1_q;
        state_nxt     = ISSUE;
      end
      ISSUE: begin
        // Read data lands this cycle; the unit samples it at the closing edge.
        div_execution_vector = ev_q;
        div_vs2              = vrf_rd_data_a;
        div_vs1              = vrf_rd_data_b;
        state_nxt            = (LAT == 1) ? WRITE : WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) state_nxt = WRITE;
      end
      WRITE: begin
        vrf_wr_en   = 1'b1;
        vrf_wr_addr = vd_q;
        vrf_wr_data = div_vd;
        done        = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything, including a command offered in IDLE.
    if (flush) state_nxt = IDLE;
  end

endmodule

// File: doc/vector_division_dispatch.md
# vector_division_dispatch

Sequencer that sits between vector decode and `vector_division_unit_freq`. It accepts one division command at a time over a valid/ready handshake and reads both source operands from the vector register file (VRF). It presents them to the division unit, waits out the unit's fixed register latency, and writes the result back to the VRF with a single-cycle `done` pulse.

## Interface
- `LAT`, default 2: cycles from the issue edge to a valid `div_vd`; legal range 1..15.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of any command in flight.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_execution_vector`  in  execution_vector_t  operation, SEW and sign control.
- `cmd_vs2_addr`, `cmd_vs1_addr`, `cmd_vd_addr`  in  5 each  VRF register indices.
- `vrf_rd_en`  out  1  VRF read strobe; data returns one cycle later.
- `vrf_rd_addr_a`, `vrf_rd_addr_b`  out  5 each  VRF read addresses (a = vs2, b = vs1).
- `vrf_rd_data_a`, `vrf_rd_data_b`  in  VLEN each  VRF read data.
- `div_execution_vector`  out  execution_vector_t  to the division unit.
- `div_vs2`, `div_vs1`  out  VLEN each  operands to the division unit.
- `div_vd`  in  VLEN  result from the division unit.
- `vrf_wr_en`  out  1  VRF write strobe.
- `vrf_wr_addr`  out  5  VRF write address.
- `vrf_wr_data`  out  VLEN  VRF write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, coincident with `vrf_wr_en`.

## Operation
- FSM states: IDLE, READ, ISSUE, WAIT, WRITE.
- IDLE
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch the execution vector and all three addresses, then go to READ.
- READ
  - Assert `vrf_rd_en`; drive the latched vs2 address on port a and vs1 on port b.
  - Go to ISSUE.
- ISSUE
  - Drive `div_vs2` = `vrf_rd_data_a`, `div_vs1` = `vrf_rd_data_b`, and `div_execution_vector` = the latched vector.
  - Clear the wait counter.
  - Go to WAIT, or to WRITE directly when `LAT` = 1.
- WAIT
  - Increment the counter each cycle.
  - Go to WRITE when the counter reaches `LAT`-2, so WAIT lasts `LAT`-1 cycles.
- WRITE
  - `vrf_wr_en` = 1, `vrf_wr_addr` = latched vd address, `vrf_wr_data` = `div_vd`, `done` = 1.
  - Go to IDLE.
- `div_*` outputs are zero in every state except ISSUE. `vrf_rd_addr_*` are zero except in READ.
- Overlapping addresses (vd equal to vs1 or vs2, or vs1 equal to vs2) need no special handling. The read always precedes the write.
- `flush` in any state: next state is IDLE. No write and no `done` occur for the aborted command. `flush` in IDLE with `cmd_valid` high: the command is not accepted and `cmd_ready` is forced to 0 that cycle.
- Reset in mid-operation: return to IDLE immediately. The command is lost.

## Timing
- Reset values: `cmd_ready` = 1; every other output is 0; state = IDLE; latched fields and counter = 0.
- The command is accepted on edge 0. The following states occupy these cycles:
  - READ: cycle 1.
  - ISSUE: cycle 2.
  - WAIT: cycles 3..(1+`LAT`).
  - WRITE: cycle 2+`LAT`.
  - IDLE, with `cmd_ready` high again: cycle 3+`LAT`.
- With `LAT` = 2: write and `done` in cycle 4. The next command can be accepted in cycle 5, so throughput is one command per 5 cycles.
- `cmd_ready` is low whenever `busy` is high. Back-to-back commands stall with no loss.
- The division unit samples its inputs at the end of ISSUE.

## Structure
- The existing shared package supplies `execution_vector_t` and `VLEN`.
- Add to the shared package: `VRF_ADDR_WIDTH` = 5 and the enum `vdd_state_t` {IDLE, READ, ISSUE, WAIT, WRITE}.
- No sub-module. The FSM, counter and latches live in one module.
- `vector_division_unit_freq` and the VRF are instantiated beside this block at the parent level, not inside it.

## Test plan
- Basic divide:
  - Setup: VRF r3 = all 32-bit elements 0x00000010, r4 = all 0x00000004; unsigned divide, SEW = 32, vd = r5, `LAT` = 2.
  - Required: r5 written in cycle 4 with all elements 0x00000004; `done` high for exactly that one cycle.
- Back-to-back stall:
  - Stimulus: `cmd_valid` held high for two commands.
  - Required: the second command is accepted in cycle 5; `cmd_ready` is low in cycles 1-4.
- Address overlap:
  - Stimulus: vs2 = vs1 = vd = r7, with r7 = all 0x00000009.
  - Required: r7 is written as all 0x00000001.
- Flush:
  - Stimulus: `flush` asserted in the WAIT cycle.
  - Required: no `vrf_wr_en`, no `done`; IDLE and `cmd_ready` = 1 on the next cycle.
- Reset during WAIT:
  - Stimulus: `reset_n` pulled low in the WAIT cycle.
  - Required: all outputs go to their reset values immediately. A new command issued after release completes normally.
- `LAT` = 1 build:
  - Required: WAIT is skipped and the write occurs in cycle 3.
